// File: rtl/reg_file_2r1w.sv
`default_nettype none
//==============================================================================
// Module      : reg_file_2r1w
// Description : Parametrised register file, two read ports and one write port,
//               with optional hardwired zero register and optional registered
//               reads. Define REGFILE_BYPASS_EN to forward an accepted write to
//               a same-cycle read of the same address.
// Revision    : 1.0 - initial release
//==============================================================================
module reg_file_2r1w #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REGS        = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int ZERO_REG        = 1,
    parameter int READ_REGISTERED = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] src_one,
    input  logic [ADDR_WIDTH-1:0] src_two,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] out_one,
    output logic [DATA_WIDTH-1:0] out_two
);

    // One extra bit so a NUM_REGS equal to 2**ADDR_WIDTH still fits.
    localparam logic [ADDR_WIDTH:0] c_num_regs = (ADDR_WIDTH + 1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic                  w_dest_in_range;
    logic                  w_dest_is_zero;
    logic                  w_write_accept;
    logic [DATA_WIDTH-1:0] w_rd_one;
    logic [DATA_WIDTH-1:0] w_rd_two;

    assign w_dest_in_range = ({1'b0, dest} < c_num_regs);
    assign w_dest_is_zero  = (ZERO_REG != 0) && (dest == '0);
    assign w_write_accept  = write_enable && !reset && w_dest_in_range && !w_dest_is_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_accept) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (dest == ADDR_WIDTH'(i)) begin
                    r_regs[i] <= data_in;
                end
            end
        end
    end

    // Decoded mux rather than a direct index: out-of-range addresses fall
    // through to zero and no index can exceed the array bounds.
    function automatic logic [DATA_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((addr == ADDR_WIDTH'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
                v = r_regs[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (w_write_accept && (addr == dest)) begin
            v = data_in;
        end
`else
        // Without forwarding a same-cycle read returns the pre-write contents.
        v = v;
`endif
        return v;
    endfunction

    always_comb begin
        w_rd_one = lookup(src_one);
        w_rd_two = lookup(src_two);
    end

    generate
        if (READ_REGISTERED != 0) begin : g_read_registered
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_one <= '0;
                    out_two <= '0;
                end else begin
                    out_one <= w_rd_one;
                    out_two <= w_rd_two;
                end
            end
        end else begin : g_read_comb
            assign out_one = w_rd_one;
            assign out_two = w_rd_two;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
//==============================================================================
// Module      : tb_reg_file_2r1w
// Description : Directed bench for reg_file_2r1w; drives two instances (default
//               combinational/zero-reg and a 24-entry registered-read variant)
//               from the same stimulus. Honours REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst_unused;
    logic        reset;
    logic [4:0]  src_one;
    logic [4:0]  src_two;
    logic [4:0]  dest;
    logic        write_enable;
    logic [31:0] data_in;
    logic [31:0] a_out_one;
    logic [31:0] a_out_two;
    logic [31:0] b_out_one;
    logic [31:0] b_out_two;

    int checks;
    int failures;

    logic [31:0] exp_a [32];
    logic [31:0] exp_b [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    reg_file_2r1w u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .src_one      (src_one),
        .src_two      (src_two),
        .dest         (dest),
        .write_enable (write_enable),
        .data_in      (data_in),
        .out_one      (a_out_one),
        .out_two      (a_out_two)
    );

    reg_file_2r1w #(
        .DATA_WIDTH      (32),
        .NUM_REGS        (24),
        .ADDR_WIDTH      (5),
        .ZERO_REG        (0),
        .READ_REGISTERED (1)
    ) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .src_one      (src_one),
        .src_two      (src_two),
        .dest         (dest),
        .write_enable (write_enable),
        .data_in      (data_in),
        .out_one      (b_out_one),
        .out_two      (b_out_two)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] val);
        dest         = addr;
        data_in      = val;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    // Sweep every address; both instances are compared against their models.
    task automatic sweep(input string tag);
        for (int a = 0; a < 32; a++) begin
            src_one = 5'(a);
            src_two = 5'(31 - a);
            tick();
            check({tag, "_a1"}, a_out_one, exp_a[a]);
            check({tag, "_a2"}, a_out_two, exp_a[31 - a]);
            check({tag, "_b1"}, b_out_one, exp_b[a]);
            check({tag, "_b2"}, b_out_two, exp_b[31 - a]);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_unused   = 1'b0;
        reset        = 1'b1;
        src_one      = '0;
        src_two      = '0;
        dest         = '0;
        write_enable = 1'b0;
        data_in      = '0;
        for (int i = 0; i < 32; i++) begin
            exp_a[i] = '0;
            exp_b[i] = '0;
        end
        tick();
        reset = 1'b0;

        // 1: everything reads zero after reset
        sweep("reset");

        // 2: write reg 5, registered port holds until the next edge
        write_reg(5'd5, 32'hDEADBEEF);
        exp_a[5] = 32'hDEADBEEF;
        exp_b[5] = 32'hDEADBEEF;
        src_one = 5'd5;
        src_two = 5'd5;
        #1;
        check("rd5_comb_a1", a_out_one, 32'hDEADBEEF);
        check("rd5_comb_a2", a_out_two, 32'hDEADBEEF);
        check("rd5_hold_b1", b_out_one, 32'h0);
        tick();
        check("rd5_reg_b1", b_out_one, 32'hDEADBEEF);
        check("rd5_reg_b2", b_out_two, 32'hDEADBEEF);

        // 3: register 0 hardwired in A, ordinary in B
        write_reg(5'd0, 32'h12345678);
        exp_b[0] = 32'h12345678;
        src_one = 5'd0;
        src_two = 5'd0;
        tick();
        check("r0_zero_a1", a_out_one, 32'h0);
        check("r0_zero_a2", a_out_two, 32'h0);
        check("r0_b1", b_out_one, 32'h12345678);
        check("r0_b2", b_out_two, 32'h12345678);

        // 4: dest 30 is in range for A, out of range for B
        write_reg(5'd30, 32'hAAAA5555);
        exp_a[30] = 32'hAAAA5555;
        src_one = 5'd30;
        src_two = 5'd23;
        tick();
        check("r30_a1", a_out_one, 32'hAAAA5555);
        check("r23_a2", a_out_two, 32'h0);
        check("r30_oor_b1", b_out_one, 32'h0);
        check("r23_b2", b_out_two, 32'h0);
        sweep("oor");

        // 5: same-cycle write and read of reg 7
        write_reg(5'd7, 32'h11111111);
        src_one      = 5'd7;
        dest         = 5'd7;
        data_in      = 32'hCAFEF00D;
        write_enable = 1'b1;
        #1;
        check("fwd_comb_a1", a_out_one, c_bypass ? 32'hCAFEF00D : 32'h11111111);
        tick();
        write_enable = 1'b0;
        check("fwd_reg_b1", b_out_one, c_bypass ? 32'hCAFEF00D : 32'h11111111);
        check("after_edge_a1", a_out_one, 32'hCAFEF00D);
        tick();
        check("after_edge_b1", b_out_one, 32'hCAFEF00D);
        exp_a[7] = 32'hCAFEF00D;
        exp_b[7] = 32'hCAFEF00D;

        // discarded writes never forward: reg 0 in A, dest 30 in B
        src_one      = 5'd0;
        src_two      = 5'd30;
        dest         = 5'd0;
        data_in      = 32'h55AA55AA;
        write_enable = 1'b1;
        #1;
        check("nofwd_r0_a1", a_out_one, 32'h0);
        check("r30_keep_a2", a_out_two, 32'hAAAA5555);
        tick();
        write_enable = 1'b0;
        check("fwd_r0_b1", b_out_one, c_bypass ? 32'h55AA55AA : 32'h12345678);
        check("r30_oor_b2", b_out_two, 32'h0);
        exp_b[0] = 32'h55AA55AA;
        dest         = 5'd30;
        write_enable = 1'b1;
        #1;
        check("fwd_r30_a2", a_out_two, c_bypass ? 32'h55AA55AA : 32'hAAAA5555);
        tick();
        write_enable = 1'b0;
        check("nofwd_oor_b2", b_out_two, 32'h0);
        check("r30_new_a2", a_out_two, 32'h55AA55AA);
        exp_a[30] = 32'h55AA55AA;
        sweep("mid");

        // 6: reset overrides a same-cycle write
        write_reg(5'd1, 32'h01010101);
        write_reg(5'd2, 32'h02020202);
        write_reg(5'd3, 32'h03030303);
        src_one = 5'd1;
        src_two = 5'd3;
        tick();
        check("pre_rst_b1", b_out_one, 32'h01010101);
        check("pre_rst_a2", a_out_two, 32'h03030303);
        reset        = 1'b1;
        dest         = 5'd4;
        data_in      = 32'hFFFFFFFF;
        write_enable = 1'b1;
        src_one      = 5'd1;
        src_two      = 5'd4;
        tick();
        reset        = 1'b0;
        write_enable = 1'b0;
        check("rst_a1", a_out_one, 32'h0);
        check("rst_a2", a_out_two, 32'h0);
        check("rst_b1", b_out_one, 32'h0);
        check("rst_b2", b_out_two, 32'h0);
        for (int i = 0; i < 32; i++) begin
            exp_a[i] = '0;
            exp_b[i] = '0;
        end
        sweep("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
